// File: rtl/timer_arbiter.sv
// Round-robin scheduler that time-shares one N-bit up-counter among NREQ requesters.
// The winner's interval runs to len cycles, with pause holding the count, and then pulses done.
module timer_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned N    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*N-1:0]   len,
    input  logic                pause,
    output logic [NREQ-1:0]     gnt,
    output logic                busy,
    output logic [NREQ-1:0]     done,
    output logic [N-1:0]        count
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [NREQ-1:0] gnt_q,   gnt_d;
    logic [IW-1:0]   own_q,   own_d;
    logic [IW-1:0]   ptr_q,   ptr_d;
    logic [N-1:0]    len_q,   len_d;
    logic [N-1:0]    count_q, count_d;

    logic            found;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;
    logic            last;

    // (base + off) mod NREQ, valid for off < NREQ
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IW'(s);
    endfunction

    // First pending requester at or after the pointer, wrapping upward
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = wrap_idx(ptr_q, i);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Modulo compare makes len=0 run the full 2^N cycles
    assign last = (count_q == len_q - N'(1));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        count_d = count_q;
        done    = '0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_RUN;
                    own_d   = pick;
                    gnt_d   = NREQ'(1) << pick;
                    len_d   = len[32'(pick)*N +: N];
                    count_d = '0;
                    ptr_d   = wrap_idx(pick, 1);
                end
            end
            S_RUN: begin
                if (!req[own_q]) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    count_d = '0;
                end else if (pause) begin
                    state_d = S_RUN;
                end else if (last) begin
                    done    = rst ? '0 : gnt_q;
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    count_d = '0;
                end else begin
                    count_d = count_q + N'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            own_q   <= '0;
            ptr_q   <= '0;
            len_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            count_q <= count_d;
        end
    end

    assign gnt   = gnt_q;
    assign busy  = (state_q == S_RUN);
    assign count = count_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter (NREQ=4, N=4): directed vector table, corner-case sequences,
// and random traffic checked cycle by cycle against an interval-level reference model.
module tb_timer_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] len = '0;
    logic        pause = 1'b0;
    logic [3:0]  gnt;
    logic        busy;
    logic [3:0]  done;
    logic [3:0]  count;

    timer_arbiter #(.NREQ(4), .N(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .len   (len),
        .pause (pause),
        .gnt   (gnt),
        .busy  (busy),
        .done  (done),
        .count (count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Reference model: owner, elapsed cycles and interval length as plain integers
    int m_run = 0, m_own = 0, m_el = 0, m_L = 0, m_ptr = 0;

    logic [3:0] obs_gnt, obs_done, obs_count;
    logic       obs_busy;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] len;
        logic        pause;
        logic [3:0]  gnt;
        logic        busy;
        logic [3:0]  count;
        logic [3:0]  done;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int oh2i(input logic [3:0] v);
        for (int k = 0; k < 4; k++) if (v == (4'b1 << k)) return k;
        return -1;
    endfunction

    // One clock cycle: drive, compare against model, advance model, cross the edge
    task automatic step(input logic r, input logic [3:0] rq, input logic [15:0] ln, input logic p);
        int e_gnt, e_done, w, found;
        @(negedge clk);
        rst = r; req = rq; len = ln; pause = p;
        #1;
        obs_gnt = gnt; obs_busy = busy; obs_count = count; obs_done = done;
        e_gnt  = m_run ? (1 << m_own) : 0;
        e_done = (m_run != 0 && !r && rq[m_own] && !p && (m_el + 1 == m_L)) ? (1 << m_own) : 0;
        if (check_en) begin
            chk("gnt",   32'(obs_gnt),   32'(e_gnt));
            chk("busy",  32'(obs_busy),  32'(m_run));
            chk("count", 32'(obs_count), 32'(m_run ? m_el : 0));
            chk("done",  32'(obs_done),  32'(e_done));
        end
        if (r) begin
            m_run = 0; m_el = 0; m_ptr = 0;
        end else if (m_run == 0) begin
            found = 0; w = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && rq[(m_ptr + k) % 4]) begin
                    found = 1; w = (m_ptr + k) % 4;
                end
            end
            if (found) begin
                m_run = 1; m_own = w; m_el = 0;
                m_L = int'(ln[w*4 +: 4]);
                if (m_L == 0) m_L = 16;
                m_ptr = (w + 1) % 4;
            end
        end else if (!rq[m_own]) begin
            m_run = 0; m_el = 0;
        end else if (p) begin
            m_run = 1;
        end else if (m_el + 1 == m_L) begin
            m_run = 0; m_el = 0;
        end else begin
            m_el++;
        end
    endtask

    initial begin
        int q[$];
        int n_run, max_cnt, done_at;
        logic [3:0] rq;
        logic [15:0] ln;

        // reset, single request of length 5 on requester 0
        tbl[0] = '{1'b0, 4'b0000, 16'h0005, 1'b0, 4'b0000, 1'b0, 4'd0, 4'b0000};
        tbl[1] = '{1'b0, 4'b0001, 16'h0005, 1'b0, 4'b0000, 1'b0, 4'd0, 4'b0000};
        tbl[2] = '{1'b0, 4'b0001, 16'h0005, 1'b0, 4'b0001, 1'b1, 4'd0, 4'b0000};
        tbl[3] = '{1'b0, 4'b0001, 16'h0005, 1'b0, 4'b0001, 1'b1, 4'd1, 4'b0000};
        tbl[4] = '{1'b0, 4'b0001, 16'h0005, 1'b0, 4'b0001, 1'b1, 4'd2, 4'b0000};
        tbl[5] = '{1'b0, 4'b0001, 16'h0005, 1'b0, 4'b0001, 1'b1, 4'd3, 4'b0000};
        tbl[6] = '{1'b0, 4'b0001, 16'h0005, 1'b0, 4'b0001, 1'b1, 4'd4, 4'b0001};
        tbl[7] = '{1'b0, 4'b0000, 16'h0005, 1'b0, 4'b0000, 1'b0, 4'd0, 4'b0000};
        tbl[8] = '{1'b0, 4'b0000, 16'h0005, 1'b0, 4'b0000, 1'b0, 4'd0, 4'b0000};

        step(1'b1, 4'b0, 16'h0, 1'b0);
        check_en = 1'b1;
        step(1'b1, 4'b0, 16'h0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].len, tbl[i].pause);
            chk($sformatf("vec%0d_gnt", i),   32'(obs_gnt),   32'(tbl[i].gnt));
            chk($sformatf("vec%0d_busy", i),  32'(obs_busy),  32'(tbl[i].busy));
            chk($sformatf("vec%0d_count", i), 32'(obs_count), 32'(tbl[i].count));
            chk($sformatf("vec%0d_done", i),  32'(obs_done),  32'(tbl[i].done));
        end

        // round robin: all requesting, len=2 everywhere
        step(1'b1, 4'b0, 16'h0, 1'b0);
        begin
            logic [3:0] prev;
            prev = '0;
            for (int i = 0; i < 15; i++) begin
                step(1'b0, 4'b1111, 16'h2222, 1'b0);
                if (obs_gnt != 0 && prev == 0) q.push_back(oh2i(obs_gnt));
                prev = obs_gnt;
            end
        end
        step(1'b0, 4'b0000, 16'h2222, 1'b0);
        chk("rr_grants", 32'(q.size()), 32'd5);
        for (int k = 0; k < q.size() && k < 5; k++) chk($sformatf("rr_order%0d", k), 32'(q[k]), 32'(k % 4));

        // len=0 wraps: 16 RUN cycles, count reaches 15
        step(1'b1, 4'b0, 16'h0, 1'b0);
        step(1'b0, 4'b0001, 16'h0000, 1'b0);
        n_run = 0; max_cnt = 0; done_at = -1;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 4'b0001, 16'h0000, 1'b0);
            if (obs_busy) n_run++;
            if (int'(obs_count) > max_cnt) max_cnt = int'(obs_count);
            if (obs_done != 0) begin
                done_at = n_run;
                break;
            end
        end
        chk("len0_done_cycle", 32'(done_at), 32'd16);
        chk("len0_max_count", 32'(max_cnt), 32'd15);
        step(1'b0, 4'b0000, 16'h0000, 1'b0);

        // len=1: done in first RUN cycle
        step(1'b1, 4'b0, 16'h0, 1'b0);
        step(1'b0, 4'b0001, 16'h0001, 1'b0);
        step(1'b0, 4'b0001, 16'h0001, 1'b0);
        chk("len1_busy", 32'(obs_busy), 32'd1);
        chk("len1_done", 32'(obs_done), 32'd1);
        step(1'b0, 4'b0000, 16'h0001, 1'b0);
        chk("len1_gnt_drop", 32'(obs_gnt), 32'd0);

        // pause three cycles at count=2 with len=6: done delayed by 3
        step(1'b1, 4'b0, 16'h0, 1'b0);
        step(1'b0, 4'b0001, 16'h0006, 1'b0);
        done_at = -1;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 4'b0001, 16'h0006, (i >= 2 && i < 5));
            if (i >= 2 && i < 5) chk("pause_hold", 32'(obs_count), 32'd2);
            if (obs_done != 0) begin
                done_at = i;
                break;
            end
        end
        chk("pause_done_at", 32'(done_at), 32'd8);
        step(1'b0, 4'b0000, 16'h0006, 1'b0);

        // pause exactly when count==len-1 suppresses done
        step(1'b1, 4'b0, 16'h0, 1'b0);
        step(1'b0, 4'b0001, 16'h0006, 1'b0);
        done_at = -1;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 4'b0001, 16'h0006, (i == 5));
            if (i == 5) chk("pause_last_nodone", 32'(obs_done), 32'd0);
            if (obs_done != 0) begin
                done_at = i;
                break;
            end
        end
        chk("pause_last_done_at", 32'(done_at), 32'd6);
        step(1'b0, 4'b0000, 16'h0006, 1'b0);

        // abort at count=3 of len=10; pointer already past requester 0
        step(1'b1, 4'b0, 16'h0, 1'b0);
        step(1'b0, 4'b0001, 16'h000A, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0001, 16'h000A, 1'b0);
        step(1'b0, 4'b0000, 16'h000A, 1'b0);
        chk("abort_count", 32'(obs_count), 32'd3);
        chk("abort_nodone", 32'(obs_done), 32'd0);
        step(1'b0, 4'b0011, 16'h00AA, 1'b0);
        chk("abort_idle", 32'(obs_busy), 32'd0);
        step(1'b0, 4'b0011, 16'h00AA, 1'b0);
        chk("abort_next_gnt", 32'(obs_gnt), 32'b0010);
        step(1'b0, 4'b0000, 16'h0000, 1'b0);

        // reset mid-run at count=4, then arbitration restarts at requester 0
        step(1'b1, 4'b0, 16'h0, 1'b0);
        step(1'b0, 4'b0010, 16'h0080, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0010, 16'h0080, 1'b0);
        step(1'b1, 4'b0010, 16'h0080, 1'b0);
        chk("rstrun_count", 32'(obs_count), 32'd4);
        chk("rstrun_nodone", 32'(obs_done), 32'd0);
        step(1'b0, 4'b1111, 16'h8888, 1'b0);
        chk("rstrun_gnt0", 32'(obs_gnt), 32'd0);
        chk("rstrun_busy0", 32'(obs_busy), 32'd0);
        chk("rstrun_count0", 32'(obs_count), 32'd0);
        step(1'b0, 4'b1111, 16'h8888, 1'b0);
        chk("rstrun_restart", 32'(obs_gnt), 32'b0001);

        // random traffic against the model
        rq = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 7) == 0) rq[k] = ~rq[k];
                ln[k*4 +: 4] = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 5));
            end
            step(($urandom_range(0, 199) == 0), rq, ln, ($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Round-robin scheduler that shares one N-bit up-counter (the `counter_n` datapath) among NREQ requesters, each of which needs a timed interval of a requested length. The block arbitrates pending requests, loads and runs the shared counter for the winner, and pulses a per-requester `done` when that interval expires. It sits between client logic and the counter resource, so only one interval runs at a time.

## Interface
- NREQ, 4: number of requesters (≥2).
- N, 8: counter width in bits; also the width of each length field.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request level; held high until `done` or abandonment.
- len  input  NREQ*N  flattened lengths; requester i uses bits [i*N +: N].
- pause  input  1  when high, the running count holds its value, like a deasserted counter enable.
- gnt  output  NREQ  one-hot grant, registered; all-zero when idle.
- busy  output  1  high while an interval is running (state RUN).
- done  output  NREQ  one-cycle pulse on the granted requester's bit in the final interval cycle.
- count  output  N  current value of the shared counter.

## Operation
- States: IDLE, RUN. Reset puts the block in IDLE with gnt=0, done=0, busy=0, count=0, and round-robin pointer=0.
- IDLE: if any req bit is high, pick the first set bit at or after the pointer, scanning upward with wrap-around.
  - Latch that requester's len slice into len_q.
  - Next cycle: state=RUN, gnt=one-hot(winner), count=0, busy=1.
  - Pointer becomes winner+1 mod NREQ.
  - If no req bit is high, stay in IDLE; gnt remains 0.
- RUN, per cycle, in priority order:
  1. If req[winner] is low, abort. Next cycle: IDLE, gnt=0, busy=0, count=0, no done.
  2. Else if pause is high, hold count, gnt and state. No done is issued, even when count==len_q-1.
  3. Else if count == len_q-1 (mod 2^N), assert done[winner] this cycle (combinational from state). Next cycle: IDLE, gnt=0, busy=0, count=0.
  4. Else count <= count+1.
- Length arithmetic is modulo 2^N.
  - len=1: done in the first RUN cycle.
  - len=0: runs 2^N cycles, with count reaching 2^N-1 before done.
- len is sampled only in the IDLE arbitration cycle. Later changes to len do not affect the running interval.
- req bits of non-granted requesters may change freely. They are only considered at the next IDLE cycle.
- A requester that keeps req high after its done re-enters arbitration. Round-robin guarantees that every other pending requester is served before it is served again.
- rst during RUN aborts the interval: no done pulse, and every output returns to its reset value on the next edge.

## Timing
- Request to grant: req high in IDLE cycle t, then gnt and busy are high from cycle t+1.
- Request to done (no pause): done is high in cycle t+L, where L=len (2^N for len=0). Total latency is L cycles after the grant edge.
- Each pause cycle in RUN adds one cycle to the done latency.
- gnt falls in the cycle after done.
- Back-to-back service: done in cycle d, IDLE in d+1, next gnt earliest at d+2. There is a guaranteed one-cycle gap.
- done is never asserted outside RUN, and never in a pause cycle.
- At most one done bit is high per cycle.

## Test plan
- **Reset, single request:** N=4, NREQ=4. Hold rst 2 cycles, then req=0001 and len0=5. Expect gnt=0001 one cycle later, count 0→4, done[0] in the 5th RUN cycle, gnt=0 the next cycle.
- **Round-robin:** all req=1111 held continuously, every len=2. Expect grant order 0,1,2,3,0. Each done is followed by one IDLE cycle and then the next gnt.
- **Wrap-around:** N=4, len=0. Expect count to reach 15 and done after exactly 16 RUN cycles. Separately, len=1 gives done in the first RUN cycle.
- **Pause:** len=6, pause high for 3 cycles at count=2. Expect count held at 2, done delayed by exactly 3 cycles, and no done while paused even when count==5.
- **Abort:** drop req[winner] at count=3 of len=10. Expect IDLE next cycle, no done, and the pointer already advanced to the next requester.
- **Reset mid-run:** assert rst at count=4. Expect gnt=0, busy=0, count=0 and no done on the next edge. After release, arbitration restarts from requester 0.
